// File: rtl/i3c_sram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : i3c_sram_fifo_ctrl
// Desc     : Valid/ready FIFO controller using a 1-port SRAM as storage, with a
//            registered output stage. Optional macro I3C_SRAM_FIFO_BYPASS_EN
//            lets a write into an empty FIFO load the output register directly.
// Revision : 1.0 - initial release
// ============================================================================
module i3c_sram_fifo_ctrl #(
  parameter  int Width = 32,
  parameter  int Depth = 64,
  localparam int Aw    = $clog2(Depth),
  localparam int Cw    = $clog2(Depth + 2)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic [Cw-1:0]    depth_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             ram_req_o,
  output logic             ram_write_o,
  output logic [Aw-1:0]    ram_addr_o,
  output logic [Width-1:0] ram_wdata_o,
  output logic [Width-1:0] ram_wmask_o,
  input  logic [Width-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FETCH = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam logic [Aw-1:0] c_last_addr  = Aw'(Depth - 1);
  localparam logic [Cw-1:0] c_depth      = Cw'(Depth);
  localparam logic [Cw-1:0] c_full_depth = Cw'(Depth + 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [Aw-1:0]    r_wptr;
  logic [Aw-1:0]    r_rptr;
  logic [Cw-1:0]    r_ram_cnt;
  logic [Width-1:0] r_rdata;
  logic             w_pop;
  logic             w_rd_go;
  logic             w_wr_acc;
  logic             w_wr_ram;
  logic             w_bypass;

  assign w_pop    = (r_state == ST_FULL) && rready_i;
  // The read owns the port; the following FETCH cycle always frees it for writes.
  assign w_rd_go  = (r_ram_cnt != '0) && ((r_state == ST_EMPTY) || w_pop) && !flush_i;
  assign wready_o = (r_ram_cnt < c_depth) && !w_rd_go && !flush_i;
  assign w_wr_acc = wvalid_i && wready_o;

`ifdef I3C_SRAM_FIFO_BYPASS_EN
  assign w_bypass = w_wr_acc && (r_ram_cnt == '0) && ((r_state == ST_EMPTY) || w_pop);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_wr_ram = w_wr_acc && !w_bypass;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_rd_go)       w_state_nxt = ST_FETCH;
        else if (w_bypass) w_state_nxt = ST_FULL;
      end
      ST_FETCH: w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_rd_go)       w_state_nxt = ST_FETCH;
        else if (w_bypass) w_state_nxt = ST_FULL;
        else if (w_pop)    w_state_nxt = ST_EMPTY;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush_i) w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_EMPTY;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_ram_cnt <= '0;
      r_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (flush_i) begin
        // A read landing this cycle is dropped; rdata keeps its old value.
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_ram_cnt <= '0;
      end else begin
        if (w_wr_ram) r_wptr <= (r_wptr == c_last_addr) ? '0 : r_wptr + 1'b1;
        if (w_rd_go)  r_rptr <= (r_rptr == c_last_addr) ? '0 : r_rptr + 1'b1;
        if (w_wr_ram)     r_ram_cnt <= r_ram_cnt + 1'b1;
        else if (w_rd_go) r_ram_cnt <= r_ram_cnt - 1'b1;
        if (r_state == ST_FETCH) r_rdata <= ram_rdata_i;
        else if (w_bypass)       r_rdata <= wdata_i;
      end
    end
  end

  assign rvalid_o    = (r_state == ST_FULL);
  assign rdata_o     = r_rdata;
  assign depth_o     = r_ram_cnt + {{(Cw-1){1'b0}}, (r_state != ST_EMPTY)};
  assign full_o      = (depth_o == c_full_depth);
  assign empty_o     = (depth_o == '0);
  assign ram_req_o   = w_rd_go | w_wr_ram;
  assign ram_write_o = !w_rd_go;
  assign ram_addr_o  = w_rd_go ? r_rptr : r_wptr;
  assign ram_wdata_o = wdata_i;
  assign ram_wmask_o = '1;

endmodule
`default_nettype wire
